matrix_scan_driver: RTL and testbench
=====================================

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning ACLK cycles per shift-clock half-period (legal range 1..255).
REQ-002 SHALL have parameter ROW_HOLD, default 64, meaning ACLK cycles of DISPLAY per row (legal range 1..65535).
REQ-003 SHALL have port ACLK  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  scan enable, from the AXI register slave.
REQ-006 SHALL have port pix_we  in  1  framebuffer write strobe.
REQ-007 SHALL have port pix_addr  in  9  pixel address {row[3:0], col[4:0]}.
REQ-008 SHALL have port pix_rgb  in  3  pixel colour {R,G,B}.
REQ-009 SHALL have ports R1,G1,B1,R2,G2,B2  out  1 each  panel data, upper half (rows 0-7) and lower half (rows 8-15).
REQ-010 SHALL have port A  out  3  panel row address.
REQ-011 SHALL have port SCLK  out  1  panel shift clock.
REQ-012 SHALL have port LAT  out  1  panel latch strobe, active-high.
REQ-013 SHALL have port OE_N  out  1  panel output enable, active-low.
REQ-014 SHALL have port frame_done  out  1  single-cycle end-of-frame pulse.

Function
REQ-015 SHALL hold a 32x16x3-bit framebuffer in two banks selected by pix_addr[8]: bank 0 = rows 0-7, bank 1 = rows 8-15.
REQ-016 SHALL write pix_rgb to pix_addr on any ACLK edge with pix_we=1, in any state, including while scanning.
REQ-017 SHALL use read-first semantics: a write to the pixel being fetched in the same cycle leaves the old value on the outputs for that row.
REQ-018 SHALL implement FSM states IDLE, SHIFT, BLANK, LATCH and DISPLAY.
REQ-019 IDLE: OE_N=1, SCLK=0, LAT=0; moves to SHIFT with row=0 when enable=1.
REQ-020 SHIFT: shifts columns 0..31 in ascending order, each over 2*CLK_DIV cycles.
REQ-021 SHIFT column timing: SCLK=0 for the first CLK_DIV cycles, SCLK=1 for the next CLK_DIV cycles.
REQ-022 SHIFT data: {R1,G1,B1}=fb[row][c] and {R2,G2,B2}=fb[row+8][c], stable throughout both SCLK phases of column c.
REQ-023 SHIFT exit: SCLK=0 when leaving SHIFT; total SHIFT length is 64*CLK_DIV cycles.
REQ-024 SHIFT OE_N: OE_N=0 if a row has been latched since leaving IDLE, else OE_N=1.
REQ-025 BLANK: 1 cycle, OE_N=1.
REQ-026 A SHALL take the new row value on the BLANK->LATCH edge and change at no other time.
REQ-027 LATCH: 1 cycle, LAT=1, OE_N=1.
REQ-028 DISPLAY: ROW_HOLD cycles, OE_N=0.
REQ-029 Row period SHALL be 64*CLK_DIV+2+ROW_HOLD cycles; with defaults that is 194 cycles per row and 1552 cycles per frame.
REQ-030 At DISPLAY end the row SHALL increment modulo 8 (7 wraps to 0).
REQ-031 frame_done SHALL be 1 during the last DISPLAY cycle of row 7 only.
REQ-032 enable SHALL be sampled only at the last DISPLAY cycle: if 1, go to SHIFT for the next row; if 0, go to IDLE with row reset to 0.
REQ-033 Deasserting enable mid-row SHALL NOT truncate the row.
REQ-034 SHALL have no combinational path from any input to any output; all panel outputs are registered.

Reset
REQ-035 ARESET=1 SHALL immediately force state=IDLE, row=0, column and phase counters=0, A=0, SCLK=0, LAT=0, OE_N=1, R1..B2=0 and frame_done=0.
REQ-036 ARESET SHALL NOT clear the framebuffer; contents are undefined after power-up until written.
REQ-037 ARESET asserted mid-row SHALL abort the row with no partial LAT pulse; scanning resumes from row 0 after release if enable=1.

Verification
REQ-038 Write fb[3][5]=3'b101 and fb[11][5]=3'b010, enable=1 -> during row-3 SHIFT column 5: {R1,G1,B1}=101, {R2,G2,B2}=010; then A=3 at LATCH.
REQ-039 Defaults, enable held 1 -> exactly 32 SCLK rising edges per row; LAT high 1 cycle every 194 cycles; frame_done period 1552 cycles; A sequence 0..7,0.
REQ-040 Deassert enable mid-SHIFT of row 2 -> row 2 completes through DISPLAY; then IDLE with OE_N=1, no further SCLK edges, A stays 2.
REQ-041 pix_we to the exact pixel being fetched in the same cycle -> current row shows the old value; next frame shows the new value.
REQ-042 ARESET pulsed during DISPLAY of row 5 -> OE_N=1 and A=0 within the same cycle; after release, first LAT occurs 64*CLK_DIV+1 cycles after SHIFT entry, with A=0.
REQ-043 CLK_DIV=1, ROW_HOLD=1 -> row period 67 cycles; SCLK toggles every cycle during SHIFT; first-row SHIFT has OE_N=1.

Source files
------------

// File: rtl/matrix_scan_driver.sv
// HUB75-style LED matrix scanner: a 32x16 RGB framebuffer is shifted out one row pair at a time,
// then latched and displayed for ROW_HOLD cycles before the next row.
module matrix_scan_driver #(
    parameter int CLK_DIV  = 2,
    parameter int ROW_HOLD = 64
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       enable,
    input  logic       pix_we,
    input  logic [8:0] pix_addr,
    input  logic [2:0] pix_rgb,
    output logic       R1,
    output logic       G1,
    output logic       B1,
    output logic       R2,
    output logic       G2,
    output logic       B2,
    output logic [2:0] A,
    output logic       SCLK,
    output logic       LAT,
    output logic       OE_N,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    localparam logic [8:0]  PH_HIGH   = 9'(CLK_DIV);
    localparam logic [8:0]  PH_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);

    logic [2:0] upperBank [256];
    logic [2:0] lowerBank [256];

    state_t      state_q;
    logic [2:0]  row_q;
    logic [4:0]  col_q;
    logic [8:0]  phase_q;
    logic [15:0] holdCnt_q;
    logic        latched_q;
    logic [2:0]  upper_q;
    logic [2:0]  lower_q;
    logic [2:0]  a_q;
    logic        sclk_q;
    logic        lat_q;
    logic        oeN_q;
    logic        frameDone_q;

    logic [2:0]  rowInc_d;
    logic [2:0]  fetchRow_d;
    logic [4:0]  fetchCol_d;
    logic [2:0]  upperPix_d;
    logic [2:0]  lowerPix_d;

    // Framebuffer is deliberately not reset; writes are accepted in every state.
    always_ff @(posedge ACLK) begin
        if (pix_we) begin
            if (pix_addr[8]) begin
                lowerBank[pix_addr[7:0]] <= pix_rgb;
            end else begin
                upperBank[pix_addr[7:0]] <= pix_rgb;
            end
        end
    end

    // Address of the column that becomes visible on the next edge, whichever state we leave from.
    always_comb begin
        rowInc_d   = row_q + 3'd1;
        fetchRow_d = row_q;
        fetchCol_d = col_q + 5'd1;
        case (state_q)
            IDLE: begin
                fetchRow_d = 3'd0;
                fetchCol_d = 5'd0;
            end
            DISPLAY: begin
                fetchRow_d = rowInc_d;
                fetchCol_d = 5'd0;
            end
            default: ;
        endcase
        upperPix_d = upperBank[{fetchRow_d, fetchCol_d}];
        lowerPix_d = lowerBank[{fetchRow_d, fetchCol_d}];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            row_q       <= 3'd0;
            col_q       <= 5'd0;
            phase_q     <= 9'd0;
            holdCnt_q   <= 16'd0;
            latched_q   <= 1'b0;
            upper_q     <= 3'd0;
            lower_q     <= 3'd0;
            a_q         <= 3'd0;
            sclk_q      <= 1'b0;
            lat_q       <= 1'b0;
            oeN_q       <= 1'b1;
            frameDone_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_q      <= 1'b0;
                    lat_q       <= 1'b0;
                    oeN_q       <= 1'b1;
                    frameDone_q <= 1'b0;
                    if (enable) begin
                        state_q   <= SHIFT;
                        row_q     <= 3'd0;
                        col_q     <= 5'd0;
                        phase_q   <= 9'd0;
                        latched_q <= 1'b0;
                        upper_q   <= upperPix_d;
                        lower_q   <= lowerPix_d;
                    end
                end
                SHIFT: begin
                    oeN_q <= ~latched_q;
                    if (phase_q == PH_LAST) begin
                        sclk_q  <= 1'b0;
                        phase_q <= 9'd0;
                        if (col_q == 5'd31) begin
                            state_q <= BLANK;
                            oeN_q   <= 1'b1;
                        end else begin
                            col_q   <= fetchCol_d;
                            upper_q <= upperPix_d;
                            lower_q <= lowerPix_d;
                        end
                    end else begin
                        phase_q <= phase_q + 9'd1;
                        sclk_q  <= (phase_q + 9'd1) >= PH_HIGH;
                    end
                end
                BLANK: begin
                    state_q <= LATCH;
                    a_q     <= row_q;
                    lat_q   <= 1'b1;
                    oeN_q   <= 1'b1;
                end
                LATCH: begin
                    state_q     <= DISPLAY;
                    lat_q       <= 1'b0;
                    oeN_q       <= 1'b0;
                    latched_q   <= 1'b1;
                    holdCnt_q   <= 16'd0;
                    frameDone_q <= (HOLD_LAST == 16'd0) && (row_q == 3'd7);
                end
                DISPLAY: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        frameDone_q <= 1'b0;
                        col_q       <= 5'd0;
                        phase_q     <= 9'd0;
                        if (enable) begin
                            state_q <= SHIFT;
                            row_q   <= rowInc_d;
                            upper_q <= upperPix_d;
                            lower_q <= lowerPix_d;
                        end else begin
                            state_q <= IDLE;
                            row_q   <= 3'd0;
                            oeN_q   <= 1'b1;
                        end
                    end else begin
                        holdCnt_q   <= holdCnt_q + 16'd1;
                        frameDone_q <= ((holdCnt_q + 16'd1) == HOLD_LAST) && (row_q == 3'd7);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oeN_q   <= 1'b1;
                end
            endcase
        end
    end

    assign {R1, G1, B1} = upper_q;
    assign {R2, G2, B2} = lower_q;
    assign A            = a_q;
    assign SCLK         = sclk_q;
    assign LAT          = lat_q;
    assign OE_N         = oeN_q;
    assign frame_done   = frameDone_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver: default instance plus a CLK_DIV=1/ROW_HOLD=1 instance,
// compared against a cycle-position model of the panel timing.
module tb_matrix_scan_driver;

    logic       ACLK = 1'b0;
    logic       ARESET, enable, pix_we;
    logic [8:0] pix_addr;
    logic [2:0] pix_rgb;
    logic       R1, G1, B1, R2, G2, B2;
    logic [2:0] A;
    logic       SCLK, LAT, OE_N, frame_done;

    logic       fastRst, fastEn, fastWe;
    logic [8:0] fastAddr;
    logic [2:0] fastRgb;
    logic       fR1, fG1, fB1, fR2, fG2, fB2;
    logic [2:0] fA;
    logic       fSclk, fLat, fOeN, fFrameDone;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    matrix_scan_driver dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .pix_we(pix_we),
        .pix_addr(pix_addr), .pix_rgb(pix_rgb),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .A(A), .SCLK(SCLK), .LAT(LAT), .OE_N(OE_N), .frame_done(frame_done)
    );

    matrix_scan_driver #(.CLK_DIV(1), .ROW_HOLD(1)) dutFast (
        .ACLK(ACLK), .ARESET(fastRst), .enable(fastEn), .pix_we(fastWe),
        .pix_addr(fastAddr), .pix_rgb(fastRgb),
        .R1(fR1), .G1(fG1), .B1(fB1), .R2(fR2), .G2(fG2), .B2(fB2),
        .A(fA), .SCLK(fSclk), .LAT(fLat), .OE_N(fOeN), .frame_done(fFrameDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] addr, input logic [2:0] rgb);
        pix_we   = 1'b1;
        pix_addr = addr;
        pix_rgb  = rgb;
        tick();
        pix_we   = 1'b0;
    endtask

    initial begin
        int rp, r, n;
        int sclkBad, latBad, oeBad, fdBad, aBad;
        int latCount, riseCount, fdCount, fdFirst, fdSecond;
        logic prevSclk, expSclk, expLat, expOe, expFd;
        logic [2:0] expA;

        ARESET = 1'b1; enable = 1'b0; pix_we = 1'b0; pix_addr = '0; pix_rgb = '0;
        fastRst = 1'b1; fastEn = 1'b0; fastWe = 1'b0; fastAddr = '0; fastRgb = '0;
        repeat (3) tick();

        checkOutput("reset OE_N", OE_N, 1'b1);
        checkOutput("reset SCLK", SCLK, 1'b0);
        checkOutput("reset LAT", LAT, 1'b0);
        checkOutput("reset A", A, 3'd0);
        checkOutput("reset frame_done", frame_done, 1'b0);
        checkOutput("reset data", {R1, G1, B1, R2, G2, B2}, 6'd0);

        ARESET = 1'b0;
        tick();
        applyStimulus(9'b0_011_00101, 3'b101);
        applyStimulus(9'b1_011_00101, 3'b010);
        applyStimulus(9'b0_100_00111, 3'b110);
        tick();
        checkOutput("idle OE_N", OE_N, 1'b1);
        checkOutput("idle SCLK", SCLK, 1'b0);

        // k counts cycles from SHIFT entry of row 0; enable drops mid-SHIFT of row 2 in the third frame.
        enable = 1'b1;
        tick();
        sclkBad = 0; latBad = 0; oeBad = 0; fdBad = 0; aBad = 0;
        latCount = 0; riseCount = 0; fdCount = 0; fdFirst = -1; fdSecond = -1;
        prevSclk = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            rp = k % 194;
            r  = (k / 194) % 8;
            if (k >= 3686) begin
                expSclk = 1'b0; expLat = 1'b0; expOe = 1'b1; expFd = 1'b0; expA = 3'd2;
            end else begin
                expSclk = (rp < 128) && ((rp % 4) >= 2);
                expLat  = (rp == 129);
                expOe   = (rp < 128) ? (k < 194) : (rp < 130);
                expFd   = (r == 7) && (rp == 193);
                expA    = (rp >= 129) ? 3'(r) : ((k < 194) ? 3'd0 : 3'((r + 7) % 8));
            end
            if (SCLK !== expSclk) sclkBad++;
            if (LAT !== expLat) latBad++;
            if (OE_N !== expOe) oeBad++;
            if (frame_done !== expFd) fdBad++;
            if (A !== expA) aBad++;
            if (LAT === 1'b1) latCount++;
            if (SCLK === 1'b1 && prevSclk === 1'b0) riseCount++;
            prevSclk = SCLK;
            if (frame_done === 1'b1) begin
                fdCount++;
                if (fdFirst < 0) fdFirst = k; else if (fdSecond < 0) fdSecond = k;
            end
            if (k == 602 || k == 605) begin
                checkOutput("row3 col5 upper", {R1, G1, B1}, 3'b101);
                checkOutput("row3 col5 lower", {R2, G2, B2}, 3'b010);
            end
            if (k == 803) begin
                pix_we = 1'b1; pix_addr = 9'b0_100_00111; pix_rgb = 3'b001;
            end
            if (k == 804) pix_we = 1'b0;
            if (k == 804 || k == 807) checkOutput("read-first old pixel", {R1, G1, B1}, 3'b110);
            if (k == 2356) checkOutput("next frame new pixel", {R1, G1, B1}, 3'b001);
            if (k == 3502) enable = 1'b0;
            tick();
        end
        checkOutput("SCLK timing mismatches", sclkBad, 0);
        checkOutput("LAT timing mismatches", latBad, 0);
        checkOutput("OE_N timing mismatches", oeBad, 0);
        checkOutput("frame_done timing mismatches", fdBad, 0);
        checkOutput("A sequence mismatches", aBad, 0);
        checkOutput("LAT pulse count", latCount, 19);
        checkOutput("SCLK rising edges", riseCount, 608);
        checkOutput("frame_done count", fdCount, 2);
        checkOutput("frame_done period", fdSecond - fdFirst, 1552);
        checkOutput("idle after disable A", A, 3'd2);
        checkOutput("idle after disable OE_N", OE_N, 1'b1);

        // Reset during DISPLAY of row 5, then restart from row 0.
        enable = 1'b1;
        tick();
        repeat (1110) tick();
        checkOutput("row5 display OE_N", OE_N, 1'b0);
        checkOutput("row5 display A", A, 3'd5);
        ARESET = 1'b1;
        #1;
        checkOutput("async reset OE_N", OE_N, 1'b1);
        checkOutput("async reset A", A, 3'd0);
        checkOutput("async reset LAT", LAT, 1'b0);
        tick();
        ARESET = 1'b0;
        tick();
        checkOutput("restart first row OE_N", OE_N, 1'b1);
        n = 0;
        while (LAT !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checkOutput("restart cycles to LAT", n, 129);
        checkOutput("restart LAT A", A, 3'd0);

        // Fastest configuration: 67-cycle rows.
        fastRst = 1'b0;
        fastEn  = 1'b1;
        tick();
        sclkBad = 0; latBad = 0; oeBad = 0; fdBad = 0; latCount = 0; fdCount = 0;
        for (int k = 0; k < 1100; k++) begin
            rp = k % 67;
            r  = (k / 67) % 8;
            expSclk = (rp < 64) && ((rp % 2) == 1);
            expLat  = (rp == 65);
            expOe   = (rp < 64) ? (k < 67) : (rp < 66);
            expFd   = (r == 7) && (rp == 66);
            if (fSclk !== expSclk) sclkBad++;
            if (fLat !== expLat) latBad++;
            if (fOeN !== expOe) oeBad++;
            if (fFrameDone !== expFd) fdBad++;
            if (fLat === 1'b1) latCount++;
            if (fFrameDone === 1'b1) fdCount++;
            if (k == 1) checkOutput("fast SCLK high", fSclk, 1'b1);
            if (k == 2) checkOutput("fast SCLK low", fSclk, 1'b0);
            if (k == 10) checkOutput("fast first row OE_N", fOeN, 1'b1);
            tick();
        end
        checkOutput("fast SCLK mismatches", sclkBad, 0);
        checkOutput("fast LAT mismatches", latBad, 0);
        checkOutput("fast OE_N mismatches", oeBad, 0);
        checkOutput("fast frame_done mismatches", fdBad, 0);
        checkOutput("fast LAT count", latCount, 16);
        checkOutput("fast frame_done count", fdCount, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
